// File: rtl/mxint_block_quantizer_pkg.sv
// Shared types and width helpers for the MXINT block quantizer.
package mxint_pkg;

  // Block-level control states.
  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    COMPUTE = 2'd1,
    EMIT    = 2'd2
  } state_t;

  // Widest value leading_one_len can scan; sample widths must not exceed it.
  localparam int LOL_MAX_WIDTH = 64;

  // Index width for a block of block_size samples (at least one bit).
  function automatic int idx_width(input int block_size);
    return (block_size <= 2) ? 1 : $clog2(block_size);
  endfunction

  // Width able to hold any shift in 0..in_width.
  function automatic int shift_width(input int in_width);
    return $clog2(in_width + 1);
  endfunction

  // Bit length of an unsigned value: index of the leading one plus one, 0 for zero.
  function automatic int leading_one_len(input logic [LOL_MAX_WIDTH-1:0] value);
    int len;
    len = 0;
    for (int i = 0; i < LOL_MAX_WIDTH; i++) begin
      if (value[i]) len = i + 1;
    end
    return len;
  endfunction

endpackage

// File: rtl/signed_clamp.sv
// Saturates a wide signed value into a narrower signed range.
// SYMMETRIC=1 drops the most negative code so the range is +/-(2^(OUT_WIDTH-1)-1).
module signed_clamp #(
  parameter int IN_WIDTH  = 17,
  parameter int OUT_WIDTH = 8,
  parameter bit SYMMETRIC = 1'b0
) (
  input  logic signed [IN_WIDTH-1:0]  din,
  output logic signed [OUT_WIDTH-1:0] dout
);

  localparam logic signed [IN_WIDTH-1:0] MAX_VAL = IN_WIDTH'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [IN_WIDTH-1:0] MIN_VAL = SYMMETRIC ? -MAX_VAL : (-MAX_VAL - IN_WIDTH'(1));

  // Select the saturation bound or pass the in-range value through.
  always_comb begin
    dout = din[OUT_WIDTH-1:0];
    if (din > MAX_VAL) begin
      dout = MAX_VAL[OUT_WIDTH-1:0];
    end else if (din < MIN_VAL) begin
      dout = MIN_VAL[OUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mxint_block_quantizer.sv
// Streaming fixed-point to MXINT converter: collects one block, derives a
// shared exponent from the largest magnitude, then emits rounded mantissas.
module mxint_block_quantizer
  import mxint_pkg::*;
#(
  parameter int IN_WIDTH   = 16,
  parameter int MANT_WIDTH = 8,
  parameter int EXP_WIDTH  = 8,
  parameter int BLOCK_SIZE = 16,
  parameter bit SYMMETRIC  = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [IN_WIDTH-1:0]   in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic signed [MANT_WIDTH-1:0] out_mant,
  output logic [EXP_WIDTH-1:0]         out_exp,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last
);

  localparam int IDX_WIDTH   = idx_width(BLOCK_SIZE);
  localparam int SHIFT_WIDTH = shift_width(IN_WIDTH);
  localparam int SUM_WIDTH   = IN_WIDTH + 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(BLOCK_SIZE - 1);

  state_t                       state_reg;
  logic [IDX_WIDTH-1:0]         wr_idx_reg;
  logic [IDX_WIDTH-1:0]         rd_idx_reg;
  logic [IN_WIDTH-1:0]          max_abs_reg;
  logic [EXP_WIDTH-1:0]         exp_reg;
  logic signed [IN_WIDTH-1:0]   sample_mem [BLOCK_SIZE];

  logic                         in_fire;
  logic                         out_fire;
  logic [IN_WIDTH-1:0]          in_abs;
  int                           max_len;
  logic [SHIFT_WIDTH-1:0]       shift_next;
  logic signed [SUM_WIDTH-1:0]  cur_ext;
  logic signed [SUM_WIDTH-1:0]  round_sum;
  logic signed [SUM_WIDTH-1:0]  round_val;
  logic signed [MANT_WIDTH-1:0] clamp_out;

  // in_ready is forced low while reset is held even though the state already reads COLLECT.
  assign in_ready  = (state_reg == COLLECT) && !rst;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = (state_reg == EMIT);
  assign out_fire  = out_valid && out_ready;

  // Two's-complement magnitude kept unsigned so the most negative input maps to 2^(IN_WIDTH-1).
  assign in_abs  = in_data[IN_WIDTH-1] ? (~$unsigned(in_data) + 1'b1) : $unsigned(in_data);
  assign max_len = leading_one_len(LOL_MAX_WIDTH'(max_abs_reg));

  // Shared shift: how far the largest magnitude exceeds the mantissa's magnitude bits.
  always_comb begin
    shift_next = '0;
    if (max_len > MANT_WIDTH - 1) begin
      shift_next = SHIFT_WIDTH'(max_len - (MANT_WIDTH - 1));
    end
  end

  // Half-up rounding of the current sample in one extra bit so the bias cannot wrap.
  always_comb begin
    cur_ext   = {sample_mem[rd_idx_reg][IN_WIDTH-1], sample_mem[rd_idx_reg]};
    round_sum = cur_ext;
    round_val = cur_ext;
    if (exp_reg != '0) begin
      round_sum = cur_ext + (SUM_WIDTH'(1) << (exp_reg - 1'b1));
      round_val = round_sum >>> exp_reg;
    end
  end

  signed_clamp #(
    .IN_WIDTH (SUM_WIDTH),
    .OUT_WIDTH(MANT_WIDTH),
    .SYMMETRIC(SYMMETRIC)
  ) u_clamp (
    .din (round_val),
    .dout(clamp_out)
  );

  // Outputs read as zero outside EMIT; during EMIT they depend only on held state, so they stay stable under backpressure.
  assign out_mant = out_valid ? clamp_out : '0;
  assign out_exp  = out_valid ? exp_reg : '0;
  assign out_last = out_valid && (rd_idx_reg == LAST_IDX);

  // Sample buffer write; contents need no reset because indices restart at zero.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      sample_mem[wr_idx_reg] <= in_data;
    end
  end

  // Block control: collect, compute the shared exponent, then emit mantissas.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= COLLECT;
      wr_idx_reg  <= '0;
      rd_idx_reg  <= '0;
      max_abs_reg <= '0;
      exp_reg     <= '0;
    end else begin
      case (state_reg)
        COLLECT: begin
          if (in_fire) begin
            if (in_abs > max_abs_reg) max_abs_reg <= in_abs;
            if (wr_idx_reg == LAST_IDX) begin
              wr_idx_reg <= '0;
              state_reg  <= COMPUTE;
            end else begin
              wr_idx_reg <= wr_idx_reg + 1'b1;
            end
          end
        end
        COMPUTE: begin
          exp_reg   <= EXP_WIDTH'(shift_next);
          state_reg <= EMIT;
        end
        EMIT: begin
          if (out_fire) begin
            if (rd_idx_reg == LAST_IDX) begin
              rd_idx_reg  <= '0;
              max_abs_reg <= '0;
              state_reg   <= COLLECT;
            end else begin
              rd_idx_reg <= rd_idx_reg + 1'b1;
            end
          end
        end
        default: state_reg <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_mxint_block_quantizer.sv
// Scoreboard bench for mxint_block_quantizer: two instances (SYMMETRIC 0 and 1)
// share the stimulus; a reference model queues expected mantissas per block.
module tb_mxint_block_quantizer;

  localparam int IN_W   = 16;
  localparam int MANT_W = 8;
  localparam int EXP_W  = 8;
  localparam int BS     = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [IN_W-1:0] in_data = '0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic in_ready0, in_ready1;
  logic signed [MANT_W-1:0] mant0, mant1;
  logic [EXP_W-1:0] exp0, exp1;
  logic valid0, valid1, last0, last1;

  always #5 clk = ~clk;

  mxint_block_quantizer #(.IN_WIDTH(IN_W), .MANT_WIDTH(MANT_W), .EXP_WIDTH(EXP_W),
                          .BLOCK_SIZE(BS), .SYMMETRIC(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
    .out_mant(mant0), .out_exp(exp0), .out_valid(valid0), .out_ready(out_ready), .out_last(last0));

  mxint_block_quantizer #(.IN_WIDTH(IN_W), .MANT_WIDTH(MANT_W), .EXP_WIDTH(EXP_W),
                          .BLOCK_SIZE(BS), .SYMMETRIC(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
    .out_mant(mant1), .out_exp(exp1), .out_valid(valid1), .out_ready(out_ready), .out_last(last1));

  typedef struct {
    int mant;
    int ex;
    int last;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int n_checks = 0;
  int n_fail = 0;
  bit manual = 1'b0;
  bit rand_ready = 1'b0;
  int blk[BS];
  bit stall[2];
  logic [16:0] prev[2];

  function automatic void check(string name, int act, int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endfunction

  // Reference: value = mant * 2^exp, exponent from the bit length of the largest magnitude.
  function automatic void push_block();
    int maxa, len, s, r, lo;
    exp_t e;
    maxa = 0;
    for (int i = 0; i < BS; i++) begin
      if ((blk[i] < 0 ? -blk[i] : blk[i]) > maxa) maxa = (blk[i] < 0 ? -blk[i] : blk[i]);
    end
    len = 0;
    while ((maxa >> len) != 0) len++;
    s = (len > MANT_W - 1) ? len - (MANT_W - 1) : 0;
    for (int i = 0; i < BS; i++) begin
      r = (s == 0) ? blk[i] : ((blk[i] + (1 << (s - 1))) >>> s);
      e.ex = s;
      e.last = (i == BS - 1) ? 1 : 0;
      for (int sym = 0; sym < 2; sym++) begin
        lo = (sym == 1) ? -127 : -128;
        e.mant = (r > 127) ? 127 : ((r < lo) ? lo : r);
        if (sym == 0) q0.push_back(e);
        else q1.push_back(e);
      end
    end
  endfunction

  function automatic int rand_sample();
    logic signed [IN_W-1:0] t;
    t = 16'($urandom);
    case ($urandom_range(0, 9))
      0: return -32768;
      1: return 0;
      default: return int'(t >>> $urandom_range(0, 15));
    endcase
  endfunction

  // Randomized backpressure when enabled; driven after the edge so the monitor samples a settled value.
  always @(posedge clk) begin
    #1;
    if (!manual) out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  task automatic mon(input int idx, input logic valid, input logic signed [MANT_W-1:0] m,
                     input logic [EXP_W-1:0] e, input logic l, input logic irdy);
    exp_t x;
    if (stall[idx]) begin
      check($sformatf("stall_valid%0d", idx), int'(valid), 1);
      check($sformatf("stall_hold%0d", idx), int'({m, e, l}), int'(prev[idx]));
    end
    if (valid) check($sformatf("in_ready_in_emit%0d", idx), int'(irdy), 0);
    if (valid && out_ready) begin
      if ((idx == 0 && q0.size() == 0) || (idx == 1 && q1.size() == 0)) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output%0d: actual mant=%0d required none", idx, m);
      end else begin
        x = (idx == 0) ? q0.pop_front() : q1.pop_front();
        $display("dut%0d out mant=%0d exp=%0d last=%0d (req %0d/%0d/%0d)", idx, m, e, l, x.mant, x.ex, x.last);
        check($sformatf("mant%0d", idx), int'(m), x.mant);
        check($sformatf("exp%0d", idx), int'(e), x.ex);
        check($sformatf("last%0d", idx), int'(l), x.last);
      end
    end
    stall[idx] = valid && !out_ready;
    prev[idx] = {m, e, l};
  endtask

  // Output monitor: compares every delivered mantissa against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      stall[0] = 1'b0;
      stall[1] = 1'b0;
    end else begin
      mon(0, valid0, mant0, exp0, last0, in_ready0);
      mon(1, valid1, mant1, exp1, last1, in_ready1);
    end
  end

  task automatic send_sample(input int v);
    int n;
    n = 0;
    @(negedge clk);
    repeat ($urandom_range(0, 1)) @(negedge clk);
    // Junk traffic while the block is busy must be ignored.
    while (!in_ready0 && n < 1000) begin
      in_valid = $urandom_range(0, 1) == 1;
      in_data = 16'($urandom);
      @(negedge clk);
      n++;
    end
    if (!in_ready0) begin
      n_checks++;
      n_fail++;
      $display("FAIL in_ready_timeout: actual=0 required=1");
    end
    in_data = 16'(v);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_block();
    for (int i = 0; i < BS; i++) send_sample(blk[i]);
    $display("in block [%0d %0d %0d %0d]", blk[0], blk[1], blk[2], blk[3]);
    push_block();
    check("compute_valid", int'(valid0), 0);
    check("compute_in_ready", int'(in_ready0), 0);
    @(posedge clk);
    #1;
    check("latency_valid", int'(valid0), 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    n_checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: actual pending=%0d required 0", q0.size() + q1.size());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_out_valid", int'(valid0) + int'(valid1), 0);
    check("rst_in_ready", int'(in_ready0) + int'(in_ready1), 0);
    check("rst_out_mant", int'(mant0), 0);
    check("rst_out_exp", int'(exp0), 0);
    check("rst_out_last", int'(last0), 0);
    q0.delete();
    q1.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();

    blk = '{1, -2, 3, -4};           send_block(); drain();
    blk = '{1000, -1000, 64, 0};     send_block(); drain();
    blk = '{255, 0, 0, 0};           send_block(); drain();
    blk = '{-32768, 100, -1, 0};     send_block(); drain();
    blk = '{0, 0, 0, 0};             send_block(); drain();
    blk = '{-255, 127, -128, 3};     send_block(); drain();

    // Backpressure on the second mantissa for three cycles.
    blk = '{500, -3, 7, 1};
    send_block();
    @(posedge clk);
    #1;
    manual = 1'b1;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b1;
    manual = 1'b0;
    drain();
    blk = '{8, -8, 1, 2};            send_block(); drain();

    // Reset with a partial block collected.
    send_sample(77);
    send_sample(-91);
    do_reset();
    blk = '{8, 8, 8, 8};             send_block(); drain();

    // Reset while the block is being emitted.
    blk = '{100, 200, 300, 400};
    send_block();
    do_reset();
    blk = '{8, 8, 8, 8};             send_block(); drain();

    // Randomized blocks with random backpressure.
    rand_ready = 1'b1;
    for (int b = 0; b < 30; b++) begin
      for (int i = 0; i < BS; i++) blk[i] = rand_sample();
      send_block();
    end
    drain();
    rand_ready = 1'b0;
    repeat (4) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
